// File: rtl/contador_ctrl.sv
// contador_ctrl: start/stop/pause controlled 4-bit up/down run counter.
// The counter runs from 0 (up) or F (down) until it reaches the limit
// latched at start. It then gives a one-cycle DONE and returns to IDLE.
// Optional macro CONTADOR_CTRL_PINGPONG_EN: when the count reaches the
// limit, it turns around and runs back to its initial value before DONE.
//
// state | meaning
// IDLE  | waiting for start, count holds last value
// RUN   | counting one step per cycle toward the terminal value
// HOLD  | paused, count frozen until pause drops or stop
// DONE  | one-cycle completion pulse, then back to IDLE

module contador_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       dir_in,
    input  logic [3:0] limit,
    output logic [3:0] count,
    output logic [1:0] state,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] count_d;
    logic       dir_q, dir_d;
    logic [3:0] lim_q, lim_d;
    logic [3:0] init_val;
    logic [3:0] step_val;
    logic [3:0] back_val;
    logic       at_end;
    logic       turn;

    assign init_val = dir_q ? 4'hF : 4'h0;
    // back_val steps against dir_q and is used only at the turnaround edge.
    assign back_val = count + (dir_q ? 4'h1 : 4'hF);

`ifdef CONTADOR_CTRL_PINGPONG_EN
    logic phase_q, phase_d;

    // On the return leg, phase inverts the effective direction.
    assign step_val = count + ((dir_q ^ phase_q) ? 4'hF : 4'h1);
    assign turn     = !phase_q && (count == lim_q) && (lim_q != init_val);
    assign at_end   = phase_q ? (count == init_val)
                              : ((count == lim_q) && (lim_q == init_val));

    // The phase register records whether the run is on its return leg.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) phase_q <= 1'b0;
        else        phase_q <= phase_d;
    end
`else
    assign step_val = count + (dir_q ? 4'hF : 4'h1);
    assign turn     = 1'b0;
    assign at_end   = (count == lim_q);
`endif

    // This register holds the state, the count and the run configuration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count   <= 4'h0;
            dir_q   <= 1'b0;
            lim_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            dir_q   <= dir_d;
            lim_q   <= lim_d;
        end
    end

    // Next-state and datapath control. In RUN the priority is stop, then the
    // terminal/turnaround check, then pause, then a step.
    always_comb begin
        state_d = state_q;
        count_d = count;
        dir_d   = dir_q;
        lim_d   = lim_q;
`ifdef CONTADOR_CTRL_PINGPONG_EN
        phase_d = phase_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef CONTADOR_CTRL_PINGPONG_EN
                phase_d = 1'b0;
`endif
                if (start) begin
                    state_d = RUN;
                    dir_d   = dir_in;
                    lim_d   = limit;
                    count_d = dir_in ? 4'hF : 4'h0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (at_end) begin
                    state_d = DONE;
                end else if (turn) begin
                    count_d = back_val;
`ifdef CONTADOR_CTRL_PINGPONG_EN
                    phase_d = 1'b1;
`endif
                end else if (pause) begin
                    state_d = HOLD;
                end else begin
                    count_d = step_val;
                end
            end
            HOLD: begin
                if (stop)        state_d = IDLE;
                else if (!pause) state_d = RUN;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;
    assign busy  = (state_q == RUN) || (state_q == HOLD);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_contador_ctrl.sv
// Testbench for contador_ctrl. The reference model plans each run as a list
// of count values. Expected outputs are queued per cycle and a monitor
// compares them after each rising edge.
`timescale 1ns/1ps

module tb_contador_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, dir_in = 1'b0;
    logic [3:0] limit = 4'h0;
    logic [3:0] count;
    logic [1:0] state;
    logic       busy, done;

    contador_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .dir_in(dir_in), .limit(limit), .count(count), .state(state),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] expq[$];

    // Reference model: 0 idle, 1 run, 2 hold, 3 done
    int         m_state = 0;
    logic [3:0] m_count = 4'h0;
    int         plan[$];
    int         idx = 0;
    int         turn_idx = -1;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got state=%b count=%h busy=%b done=%b, expected state=%b count=%h busy=%b done=%b",
                     name, $time, got[7:6], got[5:2], got[1], got[0], exp[7:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [1:0] s;
        s = m_state[1:0];
        return {s, m_count, (m_state == 1 || m_state == 2), (m_state == 3)};
    endfunction

    task automatic build_plan(input logic d, input logic [3:0] l);
        int v;
        int init;
        int n;
        plan.delete();
        init = d ? 15 : 0;
        v = init;
        plan.push_back(v);
        while (v != int'(l)) begin
            v = d ? v - 1 : v + 1;
            plan.push_back(v);
        end
        turn_idx = -1;
`ifdef CONTADOR_CTRL_PINGPONG_EN
        if (int'(l) != init) begin
            turn_idx = plan.size() - 1;
            n = turn_idx;
            for (int k = n - 1; k >= 0; k--) plan.push_back(plan[k]);
        end
`else
        n = 0;
`endif
    endtask

    task automatic model_step();
        if (!reset) begin
            m_state = 0;
            m_count = 4'h0;
        end else begin
            case (m_state)
                0: if (start) begin
                    build_plan(dir_in, limit);
                    idx = 0;
                    m_count = 4'(plan[0]);
                    m_state = 1;
                end
                1: if (stop) m_state = 0;
                   else if (idx == plan.size() - 1) m_state = 3;
                   else if (idx == turn_idx) begin idx++; m_count = 4'(plan[idx]); end
                   else if (pause) m_state = 2;
                   else begin idx++; m_count = 4'(plan[idx]); end
                2: if (stop) m_state = 0;
                   else if (!pause) m_state = 1;
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic cyc(input logic s, input logic p, input logic pa, input logic d, input logic [3:0] l);
        @(negedge clk);
        reset = 1'b1;
        start = s; stop = p; pause = pa; dir_in = d; limit = l;
        model_step();
        expq.push_back(model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0; stop = 1'b0; pause = 1'b0;
        #1;
        check("async_reset", {state, count, busy, done}, 8'h00);
        model_step();
        expq.push_back(model_out());
    endtask

    task automatic run_to_idle();
        for (int k = 0; k < 60 && m_state != 0; k++) cyc(0, 0, 0, 0, 4'h0);
    endtask

    // Monitor: compare each cycle's outputs against the queued expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("cycle", {state, count, busy, done}, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        do_reset();

        // Up run to 5
        cyc(1, 0, 0, 0, 4'h5);
        run_to_idle();
        cyc(0, 0, 0, 0, 4'h0);

        // Down run to C
        cyc(1, 0, 0, 1, 4'hC);
        run_to_idle();
        cyc(0, 0, 0, 0, 4'h0);

        // Pause at 4 for three cycles, resume, stop at 7
        cyc(1, 0, 0, 0, 4'hF);
        for (int k = 0; k < 20 && !(m_state == 1 && m_count == 4'h4); k++) cyc(0, 0, 0, 0, 4'h0);
        cyc(0, 0, 1, 0, 4'h0);
        cyc(0, 0, 1, 0, 4'h0);
        cyc(0, 0, 1, 0, 4'h0);
        for (int k = 0; k < 20 && !(m_state == 1 && m_count == 4'h7); k++) cyc(0, 0, 0, 0, 4'h0);
        cyc(0, 1, 0, 0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0);

        // Limit equal to the initial value
        cyc(1, 0, 0, 0, 4'h0);
        run_to_idle();
        cyc(1, 0, 0, 1, 4'hF);
        run_to_idle();

        // Start during RUN is ignored
        cyc(1, 0, 0, 0, 4'h6);
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, 4'h2);
        run_to_idle();

        // Reset mid-run at count 3
        cyc(1, 0, 0, 0, 4'h9);
        for (int k = 0; k < 20 && m_count != 4'h3; k++) cyc(0, 0, 0, 0, 4'h0);
        do_reset();
        cyc(0, 0, 0, 0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 20, 1'($urandom), 4'($urandom));
            end
        end
        run_to_idle();

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/contador_ctrl.md
CONTADOR_CTRL -- requirements
Module: contador_ctrl

Interface
- REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
- REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-003 SHALL have port start, input, 1 bit: begin a count run; sampled only in IDLE.
- REQ-004 SHALL have port stop, input, 1 bit: abort the run, return to IDLE.
- REQ-005 SHALL have port pause, input, 1 bit: freeze counting while high.
- REQ-006 SHALL have port dir_in, input, 1 bit: run direction, sampled with start (0 = up 0→F, 1 = down F→0).
- REQ-007 SHALL have port limit, input, 4 bits: terminal count, sampled with start.
- REQ-008 SHALL have port count, output, 4 bits: current counter register value.
- REQ-009 SHALL have port state, output, 2 bits: FSM state (IDLE=00, RUN=01, HOLD=10, DONE=11).
- REQ-010 SHALL have port busy, output, 1 bit: high in RUN or HOLD.
- REQ-011 SHALL have port done, output, 1 bit: high exactly while state is DONE, a one-cycle pulse.

Function
- REQ-012 SHALL contain its own 4-bit counter datapath: register plus adder adding 4'b0001 (up) or 4'b1111 (down); carry discarded, modulo 16.
- REQ-013 SHALL latch dir_in into dir_q and limit into lim_q on the edge where start=1 in IDLE; these are held constant for the whole run.
- REQ-014 IDLE: count holds; start=1 → RUN, with count loaded to 4'h0 if dir_in=0 or 4'hF if dir_in=1; start is ignored in every other state.
- REQ-015 RUN: priority stop > (count==lim_q) > pause > step.
  - stop → IDLE, count held.
  - count==lim_q → DONE, count held.
  - pause → HOLD, count held.
  - Otherwise count steps by ±1 per dir_q.
- REQ-016 HOLD: count held; stop → IDLE; else pause=0 → RUN, with no step on that edge.
- REQ-017 DONE: unconditionally → IDLE on next edge; count retains its final value into IDLE.
- REQ-018 Latency: start at edge N gives count=initial after N; first step after N+1; a full up-run with lim_q=L reaches DONE at edge N+L+1.
- REQ-019 lim_q equal to the initial value SHALL reach DONE on the edge after entering RUN, with zero steps.
- REQ-020 Wrap-around SHALL never occur in non-ping-pong mode, since the limit is always reached first; the datapath wrap remains modulo 16.
- REQ-021 All outputs SHALL be registered or decoded from registered state only, with no combinational input→output paths.

Reset
- REQ-022 reset=0 SHALL immediately force state=IDLE, count=4'h0, dir_q=0, lim_q=4'h0, busy=0, done=0, and phase=0.
- REQ-023 Reset asserted mid-run SHALL abort with no done pulse; after release the block waits in IDLE for start.

Configuration
- REQ-024 Macro CONTADOR_CTRL_PINGPONG_EN SHALL select ping-pong mode.
- REQ-025 Without the macro, behaviour SHALL be exactly REQ-014..REQ-020; the phase register is not implemented.
- REQ-026 With the macro defined, in RUN with phase=0 and count==lim_q:
  - phase is set to 1 and the effective direction inverts.
  - count steps back on that same edge.
  - DONE is taken only when phase=1 and count equals the initial value (0 or F).
  - phase clears on start and in IDLE.
  - If lim_q equals the initial value, DONE is taken directly.
  - stop and pause priority are unchanged.

Verification
- REQ-027 Up run: dir_in=0, limit=5, start pulse → count 0,1,2,3,4,5; DONE one cycle; IDLE with count=5; busy high for 6 cycles.
- REQ-028 Down run: dir_in=1, limit=C → count F,E,D,C; done pulse; count holds C in IDLE.
- REQ-029 Pause/stop: up run with limit=F; pause for 3 cycles at count=4 → count stays 4 and state=HOLD; resume; stop at count=7 → IDLE, count=7, no done.
- REQ-030 Boundary: limit=0 with dir_in=0 → DONE after one RUN cycle, count=0; start asserted during RUN is ignored; reset asserted at count=3 → immediate count=0, state=IDLE.
- REQ-031 With CONTADOR_CTRL_PINGPONG_EN: dir_in=0, limit=3 → count 0,1,2,3,2,1,0; then done; total RUN cycles = 7.
